// File: rtl/kv_pkg.sv
// kv_pkg: key/flag widths and request type shared by db_top, eth_top and the KVS request arbiter.
package kv_pkg;
    localparam int KV_KEY_SIZE  = 96;
    localparam int KV_FLAG_SIZE = 4;
    typedef struct packed {
        logic [KV_KEY_SIZE-1:0]  key;
        logic [KV_FLAG_SIZE-1:0] flag;
    } kv_req_t;
endpackage

// File: rtl/kv_arb_tag_fifo.sv
// kv_arb_tag_fifo: 1-bit in-order tag FIFO recording which requester owns each outstanding lookup.
module kv_arb_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        mem_q [DEPTH];
    always_comb begin
        wr_d = push_i ? wr_q + 1'b1 : wr_q;
        rd_d = pop_i ? rd_q + 1'b1 : rd_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end
    // Extra pointer bit separates full (wrapped) from empty (equal).
    assign dout_o  = mem_q[rd_q[AW-1:0]];
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

// File: rtl/kv_req_arbiter.sv
// kv_req_arbiter: round-robin share of the db_top lookup port between two requesters, results routed by tag.
// Define KV_ARB_STATS_EN to add grant/orphan statistics counters.
module kv_req_arbiter
    import kv_pkg::*;
#(
    parameter int KEY_SIZE        = KV_KEY_SIZE,
    parameter int FLAG_SIZE       = KV_FLAG_SIZE,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic                 req1_valid,
    output logic                 req0_ready,
    output logic                 req1_ready,
    input  logic [KEY_SIZE-1:0]  req0_key,
    input  logic [KEY_SIZE-1:0]  req1_key,
    input  logic [FLAG_SIZE-1:0] req0_flag,
    input  logic [FLAG_SIZE-1:0] req1_flag,
    output logic [KEY_SIZE-1:0]  db_key,
    output logic [FLAG_SIZE-1:0] db_flag,
    output logic                 db_valid,
    input  logic                 db_out_valid,
    input  logic [FLAG_SIZE-1:0] db_out_flag,
    output logic                 rsp0_valid,
    output logic                 rsp1_valid,
    output logic [FLAG_SIZE-1:0] rsp0_flag,
    output logic [FLAG_SIZE-1:0] rsp1_flag,
    output logic                 busy,
    output logic                 err_orphan
`ifdef KV_ARB_STATS_EN
   ,output logic [31:0]          stat_grant0,
    output logic [31:0]          stat_grant1,
    output logic [31:0]          stat_orphan
`endif
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    logic                 pri_q, pri_d;
    logic [CW-1:0]        count_q, count_d;
    logic [KEY_SIZE-1:0]  key_q, key_d;
    logic [FLAG_SIZE-1:0] flag_q, flag_d, rsp0_flag_q, rsp0_flag_d, rsp1_flag_q, rsp1_flag_d;
    logic                 dbv_q, rsp0_v_q, rsp1_v_q, orphan_q, orphan_d;
    logic                 win, acc, pop, orphan, head, full, empty;
    kv_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
        .clk     (clk),
        .rst     (rst),
        .push_i  (acc),
        .din_i   (win),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );
    // A same-cycle response never frees a slot, so only the registered full state gates acceptance.
    always_comb begin
        win         = (req0_valid && req1_valid) ? pri_q : req1_valid;
        acc         = (req0_valid || req1_valid) && !full;
        pop         = db_out_valid && !empty;
        orphan      = db_out_valid && empty;
        pri_d       = acc ? !win : pri_q;
        key_d       = acc ? (win ? req1_key : req0_key) : key_q;
        flag_d      = acc ? (win ? req1_flag : req0_flag) : flag_q;
        rsp0_flag_d = (pop && !head) ? db_out_flag : rsp0_flag_q;
        rsp1_flag_d = (pop && head) ? db_out_flag : rsp1_flag_q;
        count_d     = count_q + CW'(acc) - CW'(pop);
        orphan_d    = orphan_q || orphan;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri_q       <= 1'b0;
            count_q     <= '0;
            key_q       <= '0;
            flag_q      <= '0;
            dbv_q       <= 1'b0;
            rsp0_v_q    <= 1'b0;
            rsp1_v_q    <= 1'b0;
            rsp0_flag_q <= '0;
            rsp1_flag_q <= '0;
            orphan_q    <= 1'b0;
        end else begin
            pri_q       <= pri_d;
            count_q     <= count_d;
            key_q       <= key_d;
            flag_q      <= flag_d;
            dbv_q       <= acc;
            rsp0_v_q    <= pop && !head;
            rsp1_v_q    <= pop && head;
            rsp0_flag_q <= rsp0_flag_d;
            rsp1_flag_q <= rsp1_flag_d;
            orphan_q    <= orphan_d;
        end
    end
    assign req0_ready = req0_valid && !win && !full;
    assign req1_ready = req1_valid && win && !full;
    assign db_key     = key_q;
    assign db_flag    = flag_q;
    assign db_valid   = dbv_q;
    assign rsp0_valid = rsp0_v_q;
    assign rsp1_valid = rsp1_v_q;
    assign rsp0_flag  = rsp0_flag_q;
    assign rsp1_flag  = rsp1_flag_q;
    assign busy       = count_q != '0;
    assign err_orphan = orphan_q;
`ifdef KV_ARB_STATS_EN
    logic [31:0] g0_q, g1_q, orph_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g0_q       <= '0;
            g1_q       <= '0;
            orph_cnt_q <= '0;
        end else begin
            g0_q       <= g0_q + 32'(acc && !win);
            g1_q       <= g1_q + 32'(acc && win);
            orph_cnt_q <= orph_cnt_q + 32'(orphan);
        end
    end
    assign stat_grant0 = g0_q;
    assign stat_grant1 = g1_q;
    assign stat_orphan = orph_cnt_q;
`endif
endmodule

// File: tb/tb_kv_req_arbiter.sv
// tb_kv_req_arbiter: directed plan scenarios plus randomized traffic checked against a queue-based model.
module tb_kv_req_arbiter;
    localparam int KS = 96, FS = 4, MAXO = 8;
    logic clk = 0, rst = 0;
    logic v0 = 0, v1 = 0, r0, r1, ov = 0, dbv, rv0, rv1, busy, err;
    logic [KS-1:0] k0 = '0, k1 = '0, dkey;
    logic [FS-1:0] f0 = '0, f1 = '0, of = '0, dflag, rf0, rf1;
`ifdef KV_ARB_STATS_EN
    logic [31:0] sg0, sg1, sor;
    int m_g0, m_g1, m_or;
`endif
    int ncmp = 0, errs = 0;
    int m_pri;
    bit m_tags[$];
    bit m_err, e_dbv, e_rv0, e_rv1;
    logic [KS-1:0] e_key;
    logic [FS-1:0] e_flag, e_rf0, e_rf1;

    kv_req_arbiter #(.KEY_SIZE(KS), .FLAG_SIZE(FS), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req1_valid(v1), .req0_ready(r0), .req1_ready(r1),
        .req0_key(k0), .req1_key(k1), .req0_flag(f0), .req1_flag(f1),
        .db_key(dkey), .db_flag(dflag), .db_valid(dbv),
        .db_out_valid(ov), .db_out_flag(of),
        .rsp0_valid(rv0), .rsp1_valid(rv1), .rsp0_flag(rf0), .rsp1_flag(rf1),
        .busy(busy), .err_orphan(err)
`ifdef KV_ARB_STATS_EN
       ,.stat_grant0(sg0), .stat_grant1(sg1), .stat_orphan(sor)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pri = 0; m_tags.delete(); m_err = 0;
        e_dbv = 0; e_rv0 = 0; e_rv1 = 0; e_key = '0; e_flag = '0; e_rf0 = '0; e_rf1 = '0;
`ifdef KV_ARB_STATS_EN
        m_g0 = 0; m_g1 = 0; m_or = 0;
`endif
    endtask

    task automatic compare_outputs();
        chk("db_valid", dbv, e_dbv);
        chk("db_key", dkey, e_key);
        chk("db_flag", dflag, e_flag);
        chk("rsp0_valid", rv0, e_rv0);
        chk("rsp1_valid", rv1, e_rv1);
        chk("rsp0_flag", rf0, e_rf0);
        chk("rsp1_flag", rf1, e_rf1);
        chk("busy", busy, m_tags.size() != 0);
        chk("err_orphan", err, m_err);
`ifdef KV_ARB_STATS_EN
        chk("stat_grant0", sg0, m_g0);
        chk("stat_grant1", sg1, m_g1);
        chk("stat_orphan", sor, m_or);
`endif
    endtask

    // Starts and ends at a negedge; inputs held for one full clock.
    task automatic step(input bit a0, input bit a1, input logic [KS-1:0] key0, input logic [KS-1:0] key1,
                        input logic [FS-1:0] fl0, input logic [FS-1:0] fl1, input bit rv, input logic [FS-1:0] rflag);
        int w;
        bit can, acc, pop, head;
        v0 = a0; v1 = a1; k0 = key0; k1 = key1; f0 = fl0; f1 = fl1; ov = rv; of = rflag;
        #1;
        w   = (a0 && a1) ? m_pri : (a1 ? 1 : 0);
        can = m_tags.size() < MAXO;
        acc = (a0 || a1) && can;
        chk("req0_ready", r0, a0 && can && w == 0);
        chk("req1_ready", r1, a1 && can && w == 1);
        @(posedge clk);
        pop  = rv && m_tags.size() > 0;
        head = pop ? m_tags[0] : 0;
        e_dbv = acc;
        if (acc) begin e_key = w ? key1 : key0; e_flag = w ? fl1 : fl0; end
        e_rv0 = pop && !head;
        e_rv1 = pop && head;
        if (e_rv0) e_rf0 = rflag;
        if (e_rv1) e_rf1 = rflag;
        if (rv && !pop) m_err = 1;
`ifdef KV_ARB_STATS_EN
        if (acc && w == 0) m_g0++;
        if (acc && w == 1) m_g1++;
        if (rv && !pop) m_or++;
`endif
        if (pop) void'(m_tags.pop_front());
        if (acc) begin m_tags.push_back(w[0]); m_pri = 1 - w; end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(); step(0, 0, '0, '0, '0, '0, 0, '0); endtask

    task automatic do_reset();
        v0 = 0; v1 = 0; ov = 0;
        rst = 1;
        #1;
        chk("rst db_valid", dbv, 0); chk("rst db_key", dkey, 0); chk("rst db_flag", dflag, 0);
        chk("rst rsp0_valid", rv0, 0); chk("rst rsp1_valid", rv1, 0);
        chk("rst rsp0_flag", rf0, 0); chk("rst rsp1_flag", rf1, 0);
        chk("rst busy", busy, 0); chk("rst err_orphan", err, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_clear();
        compare_outputs();
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        do_reset();
        // Single requester round trip.
        step(1, 0, 96'h1, '0, 4'h1, '0, 0, '0);
        chk("single db_valid", dbv, 1); chk("single db_key", dkey, 96'h1); chk("single db_flag", dflag, 4'h1);
        idle();
        step(0, 0, '0, '0, '0, '0, 1, 4'h3);
        chk("single rsp0_valid", rv0, 1); chk("single rsp0_flag", rf0, 4'h3); chk("single rsp1_valid", rv1, 0);
        chk("single busy", busy, 0);
        // Contention: alternating grants starting with requester 0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 96'(100 + i), 96'(200 + i), '0, '0, 0, '0);
            chk("contend grant key", dkey, (i % 2) ? 96'(200 + i) : 96'(100 + i));
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, '0, '0, '0, '0, 1, FS'(i));
            chk("contend rsp0_valid", rv0, (i % 2) == 0);
            chk("contend rsp1_valid", rv1, (i % 2) == 1);
            chk("contend rsp flag", (i % 2) ? rf1 : rf0, FS'(i));
        end
        // Full: 8 accepts, then a same-cycle response does not reopen.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 96'(i), '0, '0, '0, 0, '0);
        step(1, 1, 96'h55, 96'h66, '0, '0, 0, '0);
        chk("full db_valid", dbv, 0); chk("full busy", busy, 1);
        step(1, 0, 96'h55, '0, '0, '0, 1, 4'h9);
        chk("full same-cycle db_valid", dbv, 0); chk("full rsp0_valid", rv0, 1);
        step(1, 0, 96'h77, '0, '0, '0, 0, '0);
        chk("full reopen db_valid", dbv, 1); chk("full reopen db_key", dkey, 96'h77);
        // Simultaneous accept and response with three outstanding.
        do_reset();
        step(1, 0, 96'h10, '0, '0, '0, 0, '0);
        step(0, 1, '0, 96'h11, '0, '0, 0, '0);
        step(0, 1, '0, 96'h12, '0, '0, 0, '0);
        step(0, 1, '0, 96'h13, '0, '0, 1, 4'h7);
        chk("simul rsp0_valid", rv0, 1); chk("simul rsp0_flag", rf0, 4'h7); chk("simul db_valid", dbv, 1);
        step(0, 0, '0, '0, '0, '0, 1, 4'h1);
        step(0, 0, '0, '0, '0, '0, 1, 4'h2);
        chk("simul busy after 2", busy, 1);
        step(0, 0, '0, '0, '0, '0, 1, 4'h3);
        chk("simul busy after 3", busy, 0);
        // Orphan result.
        do_reset();
        step(0, 0, '0, '0, '0, '0, 1, 4'h5);
        chk("orphan rsp0", rv0, 0); chk("orphan rsp1", rv1, 0); chk("orphan err", err, 1); chk("orphan busy", busy, 0);
        idle();
        chk("orphan sticky", err, 1);
`ifdef KV_ARB_STATS_EN
        chk("orphan stat", sor, 1);
`endif
        // Reset with four outstanding, then a late result is an orphan.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 96'(i), 96'(i + 8), '0, '0, 0, '0);
        do_reset();
        step(0, 0, '0, '0, '0, '0, 1, 4'h2);
        chk("post-reset orphan err", err, 1); chk("post-reset rsp0", rv0, 0); chk("post-reset rsp1", rv1, 0);
        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            else step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                      {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                      FS'($urandom), FS'($urandom), $urandom_range(0, 9) < 4, FS'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, errs);
        $finish;
    end
endmodule
